// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the two requester ports, the memory port and
// the status output of mem_arbiter.
//   CPU_*  : CPU requester (REQ/RW/ADDR/WDATA in, DONE out)
//   LDR_*  : loader requester (same shape as CPU)
//   RDATA  : read data of the last completed read
//   MEM_EN/RW/MAR_OUT/MDR_OUT : memory command; MEM_OUT/R : memory response
//   BUSY   : arbiter not idle
// modport slave  : the arbiter side
// modport master : the requester/memory environment side
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              CPU_REQ;
  logic              CPU_RW;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_WDATA;
  logic              CPU_DONE;
  logic              LDR_REQ;
  logic              LDR_RW;
  logic [ADDR_W-1:0] LDR_ADDR;
  logic [DATA_W-1:0] LDR_WDATA;
  logic              LDR_DONE;
  logic [DATA_W-1:0] RDATA;
  logic              MEM_EN;
  logic              RW;
  logic [ADDR_W-1:0] MAR_OUT;
  logic [DATA_W-1:0] MDR_OUT;
  logic [DATA_W-1:0] MEM_OUT;
  logic              R;
  logic              BUSY;

  modport slave (
    input  CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA,
    input  LDR_REQ, LDR_RW, LDR_ADDR, LDR_WDATA,
    input  MEM_OUT, R,
    output CPU_DONE, LDR_DONE, RDATA, MEM_EN, RW, MAR_OUT, MDR_OUT, BUSY
  );

  modport master (
    output CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA,
    output LDR_REQ, LDR_RW, LDR_ADDR, LDR_WDATA,
    output MEM_OUT, R,
    input  CPU_DONE, LDR_DONE, RDATA, MEM_EN, RW, MAR_OUT, MDR_OUT, BUSY
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (CPU, loader) arbiter in front of a single memory
// with a level ready handshake (R follows MEM_EN one cycle later).
// Ports:
//   i_Clk   : clock, rising edge
//   i_Rst_n : synchronous active-low reset
//   bus     : mem_arbiter_if.slave (requester ports, memory port, BUSY)
// Flow: IDLE grants and registers the winner's command, ACCESS holds it until
// R=1, then drops MEM_EN and pulses the winner's DONE; RELEASE waits for R=0.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// the CPU port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t            state, state_n;
  logic              grant, grant_ldr, done_now;
  logic              owner;            // 0 = CPU, 1 = loader
  logic              mem_en, rw, cpu_done, ldr_done;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr, rdata;

`ifdef MEM_ARB_RR_EN
  // Pointer names the preferred port; it only matters on a tie.
  logic rr_ptr;                        // 0 = CPU preferred
  assign grant_ldr = bus.LDR_REQ && (!bus.CPU_REQ || rr_ptr);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)   rr_ptr <= 1'b0;
    else if (grant) rr_ptr <= ~grant_ldr;   // prefer the port that just lost
  end
`else
  assign grant_ldr = bus.LDR_REQ && !bus.CPU_REQ;
`endif

  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    done_now = 1'b0;
    case (state)
      IDLE:    if (bus.CPU_REQ || bus.LDR_REQ) begin
                 grant   = 1'b1;
                 state_n = ACCESS;
               end
      ACCESS:  if (bus.R) begin
                 done_now = 1'b1;
                 state_n  = RELEASE;
               end
      RELEASE: if (!bus.R) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Command registers only load on grant, so they stay stable through ACCESS.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      mem_en   <= 1'b0;
      rw       <= 1'b0;
      mar      <= '0;
      mdr      <= '0;
      rdata    <= '0;
      owner    <= 1'b0;
      cpu_done <= 1'b0;
      ldr_done <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ldr_done <= 1'b0;
      if (grant) begin
        mem_en <= 1'b1;
        owner  <= grant_ldr;
        rw     <= grant_ldr ? bus.LDR_RW    : bus.CPU_RW;
        mar    <= grant_ldr ? bus.LDR_ADDR  : bus.CPU_ADDR;
        mdr    <= grant_ldr ? bus.LDR_WDATA : bus.CPU_WDATA;
      end
      if (done_now) begin
        mem_en   <= 1'b0;
        if (!rw) rdata <= bus.MEM_OUT;
        cpu_done <= !owner;
        ldr_done <= owner;
      end
    end
  end

  assign bus.MEM_EN   = mem_en;
  assign bus.RW       = rw;
  assign bus.MAR_OUT  = mar;
  assign bus.MDR_OUT  = mdr;
  assign bus.RDATA    = rdata;
  assign bus.CPU_DONE = cpu_done;
  assign bus.LDR_DONE = ldr_done;
  assign bus.BUSY     = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter with a small memory model
// whose ready R follows MEM_EN by one cycle plus a programmable extra wait.
module tb_mem_arbiter;
  logic i_Clk = 1'b0;
  logic i_Rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   extra = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .bus    (bus)
  );

  always #5 i_Clk = ~i_Clk;

  // Memory model
  logic [15:0] mem [0:255];
  logic        r_q;
  int          wcnt;
  assign bus.MEM_OUT = mem[bus.MAR_OUT[7:0]];
  assign bus.R       = r_q;

  always @(posedge i_Clk) begin
    if (bus.MEM_EN && bus.RW) mem[bus.MAR_OUT[7:0]] <= bus.MDR_OUT;
    if (!bus.MEM_EN) begin
      r_q  <= 1'b0;
      wcnt <= 0;
    end else if (wcnt >= extra) r_q  <= 1'b1;
    else                        wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst_n = 1'b0;
    tick();
    tick();
    i_Rst_n = 1'b1;
  endtask

  // One transaction from one port; request dropped as soon as DONE is seen.
  task automatic xact(input logic ldr, input logic rw, input logic [15:0] addr,
                      input logic [15:0] wdata,
                      output int en_cnt, output int done_cnt, output int wrong,
                      output int lat, output int unstable, output logic [15:0] rd,
                      output logic [15:0] mar_seen);
    logic mine, other;
    en_cnt = 0; done_cnt = 0; wrong = 0; lat = 0; unstable = 0;
    rd = '0; mar_seen = '0;
    if (ldr) begin
      bus.LDR_REQ = 1'b1; bus.LDR_RW = rw; bus.LDR_ADDR = addr; bus.LDR_WDATA = wdata;
    end else begin
      bus.CPU_REQ = 1'b1; bus.CPU_RW = rw; bus.CPU_ADDR = addr; bus.CPU_WDATA = wdata;
    end
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.MEM_EN) begin
        if (en_cnt == 0) mar_seen = bus.MAR_OUT;
        else if (bus.MAR_OUT !== mar_seen) unstable++;
        en_cnt++;
      end
      mine  = ldr ? bus.LDR_DONE : bus.CPU_DONE;
      other = ldr ? bus.CPU_DONE : bus.LDR_DONE;
      if (other) wrong++;
      if (mine) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i;
          rd  = bus.RDATA;
        end
        bus.CPU_REQ = 1'b0;
        bus.LDR_REQ = 1'b0;
      end
      if (done_cnt > 0 && !bus.BUSY) break;
    end
    bus.CPU_REQ = 1'b0;
    bus.LDR_REQ = 1'b0;
  endtask

  int          en_c, dn_c, wr_c, lat_c, uns_c;
  logic [15:0] rd_v, mar_v;
  logic [7:0]  order, exp_order;
  int          cpu_left, ldr_left, ndone, both, rises;
  logic        prev_en;

  initial begin
    bus.CPU_REQ = 0; bus.CPU_RW = 0; bus.CPU_ADDR = 0; bus.CPU_WDATA = 0;
    bus.LDR_REQ = 0; bus.LDR_RW = 0; bus.LDR_ADDR = 0; bus.LDR_WDATA = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h5642;
    mem[8'h10] = 16'hBEEF;
    do_reset();

    // Reset state
    chk("rst_mem_en", bus.MEM_EN, 0);
    chk("rst_busy",   bus.BUSY, 0);
    chk("rst_rw",     bus.RW, 0);
    chk("rst_mar",    bus.MAR_OUT, 0);
    chk("rst_mdr",    bus.MDR_OUT, 0);
    chk("rst_rdata",  bus.RDATA, 0);
    chk("rst_done",   {bus.CPU_DONE, bus.LDR_DONE}, 0);

    // Scenario 1: CPU write then read back
    xact(1'b0, 1'b1, 16'h0004, 16'h3206, en_c, dn_c, wr_c, lat_c, uns_c, rd_v, mar_v);
    chk("s1_en_cycles", en_c, 2);
    chk("s1_done_cnt",  dn_c, 1);
    chk("s1_latency",   lat_c, 3);
    chk("s1_mar",       mar_v, 16'h0004);
    chk("s1_rdata_keep", rd_v, 0);
    chk("s1_mem",       mem[4], 16'h3206);
    xact(1'b0, 1'b0, 16'h0004, 16'h0000, en_c, dn_c, wr_c, lat_c, uns_c, rd_v, mar_v);
    chk("s1_readback",  rd_v, 16'h3206);

    // Scenario 2: loader read of preloaded word
    xact(1'b1, 1'b0, 16'h0000, 16'h0000, en_c, dn_c, wr_c, lat_c, uns_c, rd_v, mar_v);
    chk("s2_rdata",   rd_v, 16'h5642);
    chk("s2_latency", lat_c, 3);
    chk("s2_wrong",   wr_c, 0);

    // Scenario 3: contention, 4 transactions per port
    do_reset();
    bus.CPU_REQ = 1; bus.CPU_RW = 0; bus.CPU_ADDR = 16'h0004;
    bus.LDR_REQ = 1; bus.LDR_RW = 0; bus.LDR_ADDR = 16'h0000;
    cpu_left = 4; ldr_left = 4; order = '0; ndone = 0; both = 0;
    for (int i = 0; i < 200 && (cpu_left > 0 || ldr_left > 0); i++) begin
      tick();
      if (bus.CPU_DONE && bus.LDR_DONE) both++;
      if (bus.CPU_DONE) begin
        order = {order[6:0], 1'b0}; ndone++; cpu_left--;
        if (cpu_left == 0) bus.CPU_REQ = 0;
      end
      if (bus.LDR_DONE) begin
        order = {order[6:0], 1'b1}; ndone++; ldr_left--;
        if (ldr_left == 0) bus.LDR_REQ = 0;
      end
    end
    bus.CPU_REQ = 0; bus.LDR_REQ = 0;
`ifdef MEM_ARB_RR_EN
    exp_order = 8'b0101_0101;
`else
    exp_order = 8'b0000_1111;
`endif
    chk("s3_done_total", ndone, 8);
    chk("s3_order",      order, exp_order);
    chk("s3_two_dones",  both, 0);
    for (int i = 0; i < 4; i++) tick();

    // Scenario 4: slow memory, 5 extra wait cycles
    extra = 5;
    xact(1'b0, 1'b0, 16'h0010, 16'h0000, en_c, dn_c, wr_c, lat_c, uns_c, rd_v, mar_v);
    extra = 0;
    chk("s4_en_cycles", en_c, 7);
    chk("s4_stable",    uns_c, 0);
    chk("s4_done_cnt",  dn_c, 1);
    chk("s4_latency",   lat_c, 8);
    chk("s4_rdata",     rd_v, 16'hBEEF);

    // Scenario 5: reset the cycle after grant
    bus.CPU_REQ = 1; bus.CPU_RW = 1; bus.CPU_ADDR = 16'h0020; bus.CPU_WDATA = 16'h1111;
    tick();
    chk("s5_granted", bus.MEM_EN, 1);
    i_Rst_n = 0;
    tick();
    chk("s5_mem_en", bus.MEM_EN, 0);
    chk("s5_busy",   bus.BUSY, 0);
    chk("s5_done",   {bus.CPU_DONE, bus.LDR_DONE}, 0);
    i_Rst_n = 1; bus.CPU_REQ = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.CPU_DONE || bus.LDR_DONE || bus.MEM_EN) ndone++;
    end
    chk("s5_quiet", ndone, 0);
    xact(1'b0, 1'b0, 16'h0000, 16'h0000, en_c, dn_c, wr_c, lat_c, uns_c, rd_v, mar_v);
    chk("s5_after_done", dn_c, 1);
    chk("s5_after_lat",  lat_c, 3);
    chk("s5_after_rd",   rd_v, 16'h5642);

    // Scenario 6: CPU drops request during ACCESS
    bus.CPU_REQ = 1; bus.CPU_RW = 0; bus.CPU_ADDR = 16'h0004;
    tick();
    bus.CPU_REQ = 0;
    en_c = bus.MEM_EN ? 1 : 0;
    rises = bus.MEM_EN ? 1 : 0;
    prev_en = bus.MEM_EN;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MEM_EN) en_c++;
      if (bus.MEM_EN && !prev_en) rises++;
      prev_en = bus.MEM_EN;
      if (bus.CPU_DONE) ndone++;
    end
    chk("s6_done_cnt",  ndone, 1);
    chk("s6_grants",    rises, 1);
    chk("s6_en_cycles", en_c, 2);
    chk("s6_idle",      bus.BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
